// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flush, optional multi-cycle mul/div hold (MULDIV_STALL_EN).
// Latency: control outputs are combinational; MulDiv_busy and Stall_cycles are registered one cycle behind.
// Backpressure: stalls IF/ID via PCWrite/IF2ID_Write; a mul/div op holds EX for MD_LATENCY-1 cycles.
module pipeline_stall_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_ID2EX,
    input  logic [4:0]  RtAddr_ID2EX,
    input  logic [4:0]  RsAddr_IF2ID,
    input  logic [4:0]  RtAddr_IF2ID,
    input  logic        Branch_taken_ID,
    input  logic        MulDiv_ID2EX,
    output logic        PCWrite,
    output logic        IF2ID_Write,
    output logic        IF2ID_Flush,
    output logic        ID2EX_Bubble,
    output logic        EX_Hold,
    output logic        EX2MEM_Bubble,
    output logic        MulDiv_busy,
    output logic [15:0] Stall_cycles
);

    logic load_use;
    logic md_stall;

    assign load_use = MemRead_ID2EX && (RtAddr_ID2EX != 5'd0) &&
                      ((RtAddr_ID2EX == RsAddr_IF2ID) || (RtAddr_ID2EX == RtAddr_IF2ID));

`ifdef MULDIV_STALL_EN
    typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

    state_t     state;
    logic [3:0] md_cnt;

    assign md_stall = ((state == RUN) && MulDiv_ID2EX) || (state == MD_BUSY);

    // md_cnt holds the MD_BUSY cycles still to go, counting the current one,
    // so the trigger cycle plus MD_LOAD busy cycles give MD_LATENCY-1 stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            md_cnt      <= 4'd0;
            MulDiv_busy <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MulDiv_ID2EX) begin
                        if (MD_LOAD == 4'd0) begin
                            state       <= MD_DONE;
                            MulDiv_busy <= 1'b0;
                        end else begin
                            state       <= MD_BUSY;
                            md_cnt      <= MD_LOAD;
                            MulDiv_busy <= 1'b1;
                        end
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - 4'd1;
                    if (md_cnt <= 4'd1) begin
                        state       <= MD_DONE;
                        MulDiv_busy <= 1'b0;
                    end
                end
                MD_DONE: begin
                    state       <= RUN;
                    MulDiv_busy <= 1'b0;
                end
                default: begin
                    state       <= RUN;
                    MulDiv_busy <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_muldiv;

    assign unused_muldiv = MulDiv_ID2EX;
    assign md_stall      = 1'b0;
    assign MulDiv_busy   = 1'b0;
`endif

    // Priority: mul/div hold, then load-use bubble, then branch flush.
    always_comb begin
        PCWrite       = 1'b1;
        IF2ID_Write   = 1'b1;
        IF2ID_Flush   = 1'b0;
        ID2EX_Bubble  = 1'b0;
        EX_Hold       = 1'b0;
        EX2MEM_Bubble = 1'b0;
        if (rst_n) begin
            if (md_stall) begin
                PCWrite       = 1'b0;
                IF2ID_Write   = 1'b0;
                EX_Hold       = 1'b1;
                EX2MEM_Bubble = 1'b1;
            end else if (load_use) begin
                PCWrite      = 1'b0;
                IF2ID_Write  = 1'b0;
                ID2EX_Bubble = 1'b1;
            end else if (Branch_taken_ID) begin
                IF2ID_Flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Stall_cycles <= 16'd0;
        end else if (!PCWrite && (Stall_cycles != 16'hFFFF)) begin
            Stall_cycles <= Stall_cycles + 16'd1;
        end
    end

endmodule
